// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared widths, constants and the fetch-metadata struct used by
//               the branch resolve pipe and the local branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    localparam int DEFAULT_PHT_INDEX_BITS = 7;
    localparam int DEFAULT_BHT_INDEX_BITS = 3;

    // MIPS: fall-through after a branch skips the delay slot
    localparam logic [31:0] DELAY_SLOT_OFFSET = 32'd8;

    // Prediction metadata produced in F, shared with branch_predict_local
    typedef struct packed {
        logic [31:0]                       pc;
        logic                              predict_take;
        logic [DEFAULT_BHT_INDEX_BITS-1:0] bht_index;
        logic [DEFAULT_PHT_INDEX_BITS-1:0] pht_index;
    } bp_meta_t;

endpackage : bp_pkg
`default_nettype wire

// File: rtl/bp_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : bp_stage_reg
// Description : Valid + payload pipeline register.
//               Priority: reset > flush > stall > bubble > advance.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_stage_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,       // synchronous, active-low
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             bubble_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // Stage register: flush drops the entry even while stalled; a bubble
    // leaves the stale payload in place but marks it invalid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (stall_i) begin
            valid_q <= valid_q;
        end else if (bubble_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule : bp_stage_reg
`default_nettype wire

// File: rtl/branch_resolve_pipe.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_pipe
// Description : Carries prediction metadata F->D->E->M, resolves branches in
//               E (redirect on mispredict), drives predictor training from M
//               and keeps saturating branch / mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_pipe
    import bp_pkg::*;
#(
    parameter int PHT_INDEX_BITS = DEFAULT_PHT_INDEX_BITS,
    parameter int BHT_INDEX_BITS = DEFAULT_BHT_INDEX_BITS,
    parameter int CNT_BITS       = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               pcF,
    input  logic                      predict_takeF,
    input  logic [BHT_INDEX_BITS-1:0] pc_hashingF,
    input  logic [PHT_INDEX_BITS-1:0] PHT_indexF,
    input  logic                      branchD,
    input  logic                      stallD,
    input  logic                      stallE,
    input  logic                      stallM,
    input  logic                      flushD,
    input  logic                      flushE,
    input  logic                      actually_takenE,
    input  logic [31:0]               branch_targetE,
    output logic                      mispredictE,
    output logic [31:0]               redirect_pcE,
    output logic                      branchM,
    output logic [BHT_INDEX_BITS-1:0] BHT_indexM,
    output logic [PHT_INDEX_BITS-1:0] PHT_indexM,
    output logic                      actually_takenM,
    output logic                      predict_resultM,
    output logic [CNT_BITS-1:0]       branch_cnt,
    output logic [CNT_BITS-1:0]       mispredict_cnt
);

    localparam int META_W = 32 + 1 + BHT_INDEX_BITS + PHT_INDEX_BITS;
    localparam int E_W    = META_W + 1;
    localparam int M_W    = BHT_INDEX_BITS + PHT_INDEX_BITS + 3;

    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    logic                      validD;
    logic [META_W-1:0]         metaD;
    logic                      validE;
    logic [E_W-1:0]            dataE;
    logic                      validM;
    logic [M_W-1:0]            dataM;

    logic [31:0]               pcE;
    logic                      predict_takeE;
    logic [BHT_INDEX_BITS-1:0] bht_indexE;
    logic [PHT_INDEX_BITS-1:0] pht_indexE;
    logic                      branchE;
    logic                      branch_regM;
    logic                      mispredict_regM;

    logic [CNT_BITS-1:0]       branch_cnt_q, branch_cnt_d;
    logic [CNT_BITS-1:0]       mispredict_cnt_q, mispredict_cnt_d;

    // ---------------- F -> D ----------------
    bp_stage_reg #(.WIDTH(META_W)) u_stage_d (
        .clk      (clk),
        .rst      (rst),
        .stall_i  (stallD),
        .flush_i  (flushD),
        .bubble_i (1'b0),
        .valid_i  (1'b1),
        .data_i   ({pcF, predict_takeF, pc_hashingF, PHT_indexF}),
        .valid_o  (validD),
        .data_o   (metaD)
    );

    // ---------------- D -> E (bubble when D holds but E moves) ----------------
    bp_stage_reg #(.WIDTH(E_W)) u_stage_e (
        .clk      (clk),
        .rst      (rst),
        .stall_i  (stallE),
        .flush_i  (flushE),
        .bubble_i (stallD),
        .valid_i  (validD),
        .data_i   ({metaD, branchD}),
        .valid_o  (validE),
        .data_o   (dataE)
    );

    assign pcE           = dataE[E_W-1 -: 32];
    assign predict_takeE = dataE[E_W-33];
    assign bht_indexE    = dataE[PHT_INDEX_BITS+BHT_INDEX_BITS -: BHT_INDEX_BITS];
    assign pht_indexE    = dataE[PHT_INDEX_BITS:1];
    assign branchE       = dataE[0];

    // Resolve in E; a stalled E waits so the redirect is raised exactly once
    assign mispredictE  = validE & branchE & (predict_takeE != actually_takenE) & ~stallE;
    assign redirect_pcE = !mispredictE    ? 32'd0 :
                          actually_takenE ? branch_targetE :
                                            pcE + DELAY_SLOT_OFFSET;

    // ---------------- E -> M (bubble when E holds but M moves) ----------------
    bp_stage_reg #(.WIDTH(M_W)) u_stage_m (
        .clk      (clk),
        .rst      (rst),
        .stall_i  (stallM),
        .flush_i  (1'b0),
        .bubble_i (stallE),
        .valid_i  (validE),
        .data_i   ({bht_indexE, pht_indexE, branchE, actually_takenE, mispredictE}),
        .valid_o  (validM),
        .data_o   (dataM)
    );

    assign BHT_indexM      = dataM[M_W-1 -: BHT_INDEX_BITS];
    assign PHT_indexM      = dataM[PHT_INDEX_BITS+2:3];
    assign branch_regM     = dataM[2];
    assign actually_takenM = dataM[1];
    assign mispredict_regM = dataM[0];

    // One training strobe per retired branch, held off while M is stalled
    assign branchM         = validM & branch_regM & ~stallM;
    assign predict_resultM = actually_takenM;

    // Saturating counter next-state on each retired branch
    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (branchM) begin
            if (branch_cnt_q != '1) begin
                branch_cnt_d = branch_cnt_q + CNT_ONE;
            end
            if (mispredict_regM && (mispredict_cnt_q != '1)) begin
                mispredict_cnt_d = mispredict_cnt_q + CNT_ONE;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule : branch_resolve_pipe
`default_nettype wire

// File: tb/tb_branch_resolve_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_pipe
// Description : Directed self-checking bench for branch_resolve_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF;
    logic        predict_takeF;
    logic [2:0]  pc_hashingF;
    logic [6:0]  PHT_indexF;
    logic        branchD;
    logic        stallD, stallE, stallM;
    logic        flushD, flushE;
    logic        actually_takenE;
    logic [31:0] branch_targetE;
    logic        mispredictE;
    logic [31:0] redirect_pcE;
    logic        branchM;
    logic [2:0]  BHT_indexM;
    logic [6:0]  PHT_indexM;
    logic        actually_takenM;
    logic        predict_resultM;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    branch_resolve_pipe #(
        .PHT_INDEX_BITS (7),
        .BHT_INDEX_BITS (3),
        .CNT_BITS       (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pcF             (pcF),
        .predict_takeF   (predict_takeF),
        .pc_hashingF     (pc_hashingF),
        .PHT_indexF      (PHT_indexF),
        .branchD         (branchD),
        .stallD          (stallD),
        .stallE          (stallE),
        .stallM          (stallM),
        .flushD          (flushD),
        .flushE          (flushE),
        .actually_takenE (actually_takenE),
        .branch_targetE  (branch_targetE),
        .mispredictE     (mispredictE),
        .redirect_pcE    (redirect_pcE),
        .branchM         (branchM),
        .BHT_indexM      (BHT_indexM),
        .PHT_indexM      (PHT_indexM),
        .actually_takenM (actually_takenM),
        .predict_resultM (predict_resultM),
        .branch_cnt      (branch_cnt),
        .mispredict_cnt  (mispredict_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_f();
        pcF           = 32'h0000_1000;
        predict_takeF = 1'b0;
        pc_hashingF   = 3'd0;
        PHT_indexF    = 7'd0;
    endtask

    // Push one branch through F, D, E, M and the counter-update edge
    task automatic run_branch(input logic [31:0] pc, input logic pred, input logic [2:0] bht,
                              input logic [6:0] pht, input logic taken, input logic [31:0] target,
                              input logic exp_mis, input logic [31:0] exp_redir);
        pcF = pc; predict_takeF = pred; pc_hashingF = bht; PHT_indexF = pht;
        step();
        idle_f();
        branchD = 1'b1;
        step();
        branchD = 1'b0; actually_takenE = taken; branch_targetE = target;
        #1;
        check_val("mispredictE", {31'd0, mispredictE}, {31'd0, exp_mis});
        check_val("redirect_pcE", redirect_pcE, exp_redir);
        step();
        actually_takenE = 1'b0; branch_targetE = 32'd0;
        #1;
        check_val("mispredict_once", {31'd0, mispredictE}, 32'd0);
        check_val("branchM_retire", {31'd0, branchM}, 32'd1);
        check_val("BHT_indexM", {29'd0, BHT_indexM}, {29'd0, bht});
        check_val("PHT_indexM", {25'd0, PHT_indexM}, {25'd0, pht});
        check_val("predict_resultM", {31'd0, predict_resultM}, {31'd0, taken});
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        idle_f();
        branchD = 0; stallD = 0; stallE = 0; stallM = 0; flushD = 0; flushE = 0;
        actually_takenE = 0; branch_targetE = 32'd0;
        step(); step();

        // ---- 1. reset dominance with live traffic ----
        pcF = 32'h55; predict_takeF = 1; pc_hashingF = 3'd5; PHT_indexF = 7'h7f;
        branchD = 1; actually_takenE = 1;
        step(); step();
        check_val("rst_mispredictE", {31'd0, mispredictE}, 32'd0);
        check_val("rst_redirect_pcE", redirect_pcE, 32'd0);
        check_val("rst_branchM", {31'd0, branchM}, 32'd0);
        check_val("rst_BHT_indexM", {29'd0, BHT_indexM}, 32'd0);
        check_val("rst_PHT_indexM", {25'd0, PHT_indexM}, 32'd0);
        check_val("rst_actually_takenM", {31'd0, actually_takenM}, 32'd0);
        check_val("rst_predict_resultM", {31'd0, predict_resultM}, 32'd0);
        check_val("rst_branch_cnt", branch_cnt, 32'd0);
        check_val("rst_mispredict_cnt", mispredict_cnt, 32'd0);
        rst = 1;
        step();
        check_val("release_branchM_c1", {31'd0, branchM}, 32'd0);
        step();
        check_val("release_branchM_c2", {31'd0, branchM}, 32'd0);
        check_val("release_mispredictE", {31'd0, mispredictE}, 32'd0);
        step();
        check_val("release_branchM_c3", {31'd0, branchM}, 32'd1);
        check_val("release_PHT_indexM", {25'd0, PHT_indexM}, 32'h7f);
        // reset with D, E and M all holding branches
        rst = 0;
        step();
        check_val("midrst_branchM", {31'd0, branchM}, 32'd0);
        check_val("midrst_branch_cnt", branch_cnt, 32'd0);
        rst = 1; branchD = 0; actually_takenE = 0; idle_f();
        step();
        check_val("midrst_branchM_after", {31'd0, branchM}, 32'd0);
        step(); step();
        check_val("midrst_cnt_after", branch_cnt, 32'd0);

        // ---- 2. correct prediction ----
        run_branch(32'h100, 1'b1, 3'd3, 7'h25, 1'b1, 32'h0, 1'b0, 32'h0);
        check_val("t2_branch_cnt", branch_cnt, 32'd1);
        check_val("t2_mispredict_cnt", mispredict_cnt, 32'd0);

        // ---- 3. mispredict, actually not taken ----
        run_branch(32'h200, 1'b1, 3'd1, 7'h11, 1'b0, 32'h999, 1'b1, 32'h208);
        check_val("t3_branch_cnt", branch_cnt, 32'd2);
        check_val("t3_mispredict_cnt", mispredict_cnt, 32'd1);

        // ---- 4. mispredict taken, E stalled 3 cycles ----
        pcF = 32'h300; predict_takeF = 0; pc_hashingF = 3'd2; PHT_indexF = 7'h40;
        step();
        idle_f(); branchD = 1;
        step();
        branchD = 0; actually_takenE = 1; branch_targetE = 32'h400; stallD = 1; stallE = 1;
        #1;
        check_val("t4_stall0_mis", {31'd0, mispredictE}, 32'd0);
        check_val("t4_stall0_redir", redirect_pcE, 32'd0);
        step();
        check_val("t4_stall1_mis", {31'd0, mispredictE}, 32'd0);
        check_val("t4_stall1_bubbleM", {31'd0, branchM}, 32'd0);
        step();
        check_val("t4_stall2_mis", {31'd0, mispredictE}, 32'd0);
        check_val("t4_stall2_bubbleM", {31'd0, branchM}, 32'd0);
        stallD = 0; stallE = 0;
        #1;
        check_val("t4_release_mis", {31'd0, mispredictE}, 32'd1);
        check_val("t4_release_redir", redirect_pcE, 32'h400);
        step();
        actually_takenE = 0; branch_targetE = 32'd0;
        #1;
        check_val("t4_mis_once", {31'd0, mispredictE}, 32'd0);
        check_val("t4_branchM", {31'd0, branchM}, 32'd1);
        check_val("t4_actually_takenM", {31'd0, actually_takenM}, 32'd1);
        check_val("t4_BHT_indexM", {29'd0, BHT_indexM}, 32'd2);
        step();
        check_val("t4_branch_cnt", branch_cnt, 32'd3);
        check_val("t4_mispredict_cnt", mispredict_cnt, 32'd2);

        // ---- 5a. branch held in M for 4 cycles ----
        pcF = 32'h500; predict_takeF = 1; pc_hashingF = 3'd6; PHT_indexF = 7'h12;
        step();
        idle_f(); branchD = 1;
        step();
        branchD = 0; actually_takenE = 1;
        step();
        actually_takenE = 0; stallD = 1; stallE = 1; stallM = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val("t5_stallM_branchM", {31'd0, branchM}, 32'd0);
            check_val("t5_stallM_cnt", branch_cnt, 32'd3);
            step();
        end
        stallD = 0; stallE = 0; stallM = 0;
        #1;
        check_val("t5_release_branchM", {31'd0, branchM}, 32'd1);
        check_val("t5_release_PHT", {25'd0, PHT_indexM}, 32'h12);
        step();
        check_val("t5_single_pulse", {31'd0, branchM}, 32'd0);
        check_val("t5_branch_cnt", branch_cnt, 32'd4);
        check_val("t5_mispredict_cnt", mispredict_cnt, 32'd2);

        // ---- 5b. flushE together with stallE on a branch in E ----
        pcF = 32'h600; predict_takeF = 0; pc_hashingF = 3'd7; PHT_indexF = 7'h33;
        step();
        idle_f(); branchD = 1;
        step();
        branchD = 0; actually_takenE = 1; stallD = 1; stallE = 1; flushE = 1;
        #1;
        check_val("t5b_mis_stalled", {31'd0, mispredictE}, 32'd0);
        step();
        flushE = 0; stallD = 0; stallE = 0;
        #1;
        check_val("t5b_mis_flushed", {31'd0, mispredictE}, 32'd0);
        step();
        actually_takenE = 0;
        check_val("t5b_branchM_a", {31'd0, branchM}, 32'd0);
        step();
        check_val("t5b_branchM_b", {31'd0, branchM}, 32'd0);
        check_val("t5b_branch_cnt", branch_cnt, 32'd4);
        check_val("t5b_mispredict_cnt", mispredict_cnt, 32'd2);

        // ---- fall-through address wraps modulo 2^32 ----
        run_branch(32'hFFFF_FFFC, 1'b1, 3'd4, 7'h55, 1'b0, 32'h0, 1'b1, 32'h0000_0004);
        check_val("wrap_branch_cnt", branch_cnt, 32'd5);
        check_val("wrap_mispredict_cnt", mispredict_cnt, 32'd3);

        // ---- 6. saturation ----
        force dut.branch_cnt_q     = 32'hFFFF_FFFE;
        force dut.mispredict_cnt_q = 32'hFFFF_FFFE;
        step();
        release dut.branch_cnt_q;
        release dut.mispredict_cnt_q;
        #1;
        run_branch(32'h700, 1'b1, 3'd0, 7'h01, 1'b0, 32'h0, 1'b1, 32'h708);
        check_val("sat1_branch_cnt", branch_cnt, 32'hFFFF_FFFF);
        check_val("sat1_mispredict_cnt", mispredict_cnt, 32'hFFFF_FFFF);
        run_branch(32'h800, 1'b0, 3'd1, 7'h02, 1'b1, 32'h1234, 1'b1, 32'h1234);
        run_branch(32'h900, 1'b1, 3'd2, 7'h03, 1'b0, 32'h0, 1'b1, 32'h908);
        check_val("sat3_branch_cnt", branch_cnt, 32'hFFFF_FFFF);
        check_val("sat3_mispredict_cnt", mispredict_cnt, 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_branch_resolve_pipe
`default_nettype wire

// File: doc/branch_resolve_pipe.md
Name: branch_resolve_pipe

Overview:
- Carries fetch-stage prediction metadata through the D, E and M pipeline registers.
- Resolves each branch in E: compares the prediction with the actual outcome and raises a single-cycle redirect on a mispredict.
- Drives the M-stage training interface of branch_predict_local: branchM, BHT_indexM, PHT_indexM, actually_takenM, predict_resultM.
- Keeps saturating branch and mispredict performance counters.

Parameters:
- PHT_INDEX_BITS, 7, PHT index width; must match the predictor.
- BHT_INDEX_BITS, 3, BHT index width; must match the predictor.
- CNT_BITS, 32, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset (rst==0 at posedge resets).
- pcF  in  32  fetch PC.
- predict_takeF  in  1  predictor direction for pcF.
- pc_hashingF  in  BHT_INDEX_BITS  BHT index for pcF.
- PHT_indexF  in  PHT_INDEX_BITS  PHT index for pcF.
- branchD  in  1  decoded instruction in D is a conditional branch.
- stallD / stallE / stallM  in  1 each  hold the corresponding stage register.
- flushD / flushE  in  1 each  invalidate the corresponding stage register.
- actually_takenE  in  1  branch condition result computed in E.
- branch_targetE  in  32  taken target computed in E.
- mispredictE  out  1  redirect request.
- redirect_pcE  out  32  correct next PC.
- branchM  out  1  train strobe to the predictor.
- BHT_indexM  out  BHT_INDEX_BITS  predictor training index.
- PHT_indexM  out  PHT_INDEX_BITS  predictor training index.
- actually_takenM  out  1  predictor training outcome.
- predict_resultM  out  1  predictor training outcome.
- branch_cnt  out  CNT_BITS  resolved branches.
- mispredict_cnt  out  CNT_BITS  mispredicted branches.

Behaviour:
- Reset:
  - All valid bits clear.
  - All payload registers and both counters are 0.
  - Every output is 0 in the cycle after the reset edge; this includes redirect_pcE.
- F->D register:
  - Captures {pcF, predict_takeF, pc_hashingF, PHT_indexF} each cycle with valid=1, unless stallD.
  - On stallD it holds.
- D->E register:
  - Captures the D payload plus branchD.
  - If stallD and not stallE, a bubble is inserted (validE=0).
  - On stallE it holds.
- E->M register:
  - Captures the E payload plus actually_takenE.
  - If stallE and not stallM, a bubble is inserted.
  - On stallM it holds.
- Priority per stage: rst > flush > stall > advance. flushD/flushE clear the valid bit of D/E even when that stage is stalled.
- mispredictE:
  - Combinational: validE & branchE & (predict_takeE != actually_takenE) & ~stallE.
  - Fires once per branch; it is suppressed while E is stalled and fires on the release cycle.
- redirect_pcE:
  - actually_takenE ? branch_targetE : pcE + 8 (MIPS delay slot).
  - Valid only when mispredictE=1; otherwise 0.
  - The addition is modulo 2^32 (0xFFFFFFFC + 8 = 0x00000004).
- Flushing younger stages on a mispredict is the hazard unit's job. This block never flushes itself.
- branchM:
  - validM & branchM_reg & ~stallM.
  - Exactly one pulse per retired branch, so the predictor never double-trains during an M stall.
- Training outputs: BHT_indexM, PHT_indexM and actually_takenM come from the M register. predict_resultM equals actually_takenM (the predictor trains its counters on the outcome).
- Counters:
  - branch_cnt increments on every branchM pulse.
  - mispredict_cnt increments on every branchM pulse whose registered mispredict flag (captured from E) is set.
  - Both saturate at all-ones and never wrap.
- Reset mid-operation: in-flight entries are discarded and no branchM pulse is emitted for them.

Decomposition:
- Package bp_pkg:
  - PHT_INDEX_BITS and BHT_INDEX_BITS defaults.
  - DELAY_SLOT_OFFSET (32'd8).
  - Struct bp_meta_t {pc, predict_take, bht_index, pht_index}, which is reused by branch_predict_local's port list.
- One natural sub-module, bp_stage_reg: a parameterised valid+payload register with stall/flush/bubble rules, instantiated three times.

Test Plan:
1. Reset dominance: drive rst=0 with pipeline traffic -> all outputs 0 on the next edge. Release rst=1 -> first branchM no earlier than 3 cycles after the first fetch.
2. Correct prediction: pcF=0x100, predict_takeF=1, branchD=1, actually_takenE=1 -> mispredictE=0. Two cycles later branchM=1 with PHT_indexM/BHT_indexM equal to the F values, predict_resultM=1, branch_cnt=1, mispredict_cnt=0.
3. Mispredict not-taken: pcF=0x200, predict_takeF=1, actually_takenE=0 -> mispredictE=1 for exactly one cycle, redirect_pcE=0x208; mispredict_cnt=1 after the M retire.
4. Mispredict taken with E stall: predict_takeF=0, actually_takenE=1, branch_targetE=0x400, stallE held 3 cycles -> mispredictE=0 while stalled, then one pulse with redirect_pcE=0x400. M receives bubbles during the stall.
5. M stall plus flush: stallM=1 for 4 cycles with a branch in M -> branchM=0 throughout and a single pulse on release. flushE asserted together with stallE on a branch in E -> that branch never reaches M and the counters are unchanged.
6. Counter saturation: preload via a force to all-ones minus 1, retire 3 mispredicted branches -> both counters stick at 0xFFFFFFFF.
